// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the test-counter datapath.
// Parity support in uart_tx is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

    // Even parity over up to 9 data bits; callers zero-extend narrower words.
    function automatic logic even_parity(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Shared by uart_tx and a future uart_rx.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // NOTE: reset is synchronous, so it lives inside the clocked branch, not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            count <= '0;
        end else if (count == TERMINAL) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign o_tick = (count == TERMINAL);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one word per i_dv in IDLE, sent LSB first with start/stop framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_dv,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_tx_state_t   state;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift;
    logic             tick;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    // Held clear in IDLE; every other state change happens on a tick, where the counter wraps to 0.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) baud (
        .clk    (clk),
        .i_reset(i_reset),
        .i_clear(state == IDLE),
        .o_tick (tick)
    );

    // NOTE: every register here is state, so only non-blocking assignments appear in this block.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            o_tx    <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_dv) begin
                        shift  <= i_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= even_parity(9'(i_data));
`endif
                        o_tx   <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        o_tx    <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            o_tx  <= parity_bit;
                            state <= PARITY;
`else
                            o_tx  <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            o_tx    <= shift[0];
                            shift   <= shift >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        o_tx    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one 1-stop-bit and one 2-stop-bit instance against a frame-list model.
// Honours UART_TX_PARITY_EN when the bench is compiled with it.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int WIDTH = 8;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dv1 = 1'b0, dv2 = 1'b0;
    logic [WIDTH-1:0] data1 = '0, data2 = '0;
    logic             tx1, busy1, done1;
    logic             tx2, busy2, done2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clk(clk), .i_reset(rst), .i_dv(dv1), .i_data(data1),
        .o_tx(tx1), .o_busy(busy1), .o_done(done1)
    );

    uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .clk(clk), .i_reset(rst), .i_dv(dv2), .i_data(data2),
        .o_tx(tx2), .o_busy(busy2), .o_done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        else passed++;
    endtask

    function automatic logic out_tx(input int inst);
        return (inst == 0) ? tx1 : tx2;
    endfunction

    function automatic logic out_busy(input int inst);
        return (inst == 0) ? busy1 : busy2;
    endfunction

    function automatic logic out_done(input int inst);
        return (inst == 0) ? done1 : done2;
    endfunction

    task automatic set_dv(input int inst, input logic v, input logic [WIDTH-1:0] d);
        if (inst == 0) begin dv1 = v; data1 = d; end
        else           begin dv2 = v; data2 = d; end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame as a list of line levels, one entry per bit period.
    task automatic build_frame(input int inst, input logic [WIDTH-1:0] d, output bit q[$]);
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < WIDTH; i++) q.push_back(d[i]);
        if (PARITY_ON) q.push_back(^d);
        for (int s = 0; s < ((inst == 0) ? 1 : 2); s++) q.push_back(1'b1);
    endtask

    // Called just after a clock edge; i_dv is raised for `hold` cycles starting with acceptance.
    task automatic run_frame(input int inst, input logic [WIDTH-1:0] d, input int hold);
        bit q[$];
        int n;
        build_frame(inst, d, q);
        n = q.size() * CPB;
        set_dv(inst, 1'b1, d);
        for (int k = 0; k < n; k++) begin
            tick();
            if (k + 1 >= hold) set_dv(inst, 1'b0, d);
            check($sformatf("tx[%0d] bit%0d", inst, k / CPB), out_tx(inst), q[k / CPB]);
            check($sformatf("busy[%0d] c%0d", inst, k), out_busy(inst), 1'b1);
            check($sformatf("done_early[%0d] c%0d", inst, k), out_done(inst), 1'b0);
        end
        tick();
        check($sformatf("busy_fall[%0d]", inst), out_busy(inst), 1'b0);
        check($sformatf("done_pulse[%0d]", inst), out_done(inst), 1'b1);
        check($sformatf("tx_at_done[%0d]", inst), out_tx(inst), 1'b1);
        for (int k = 0; k < CPB + 1; k++) begin
            tick();
            check($sformatf("done_width[%0d]", inst), out_done(inst), 1'b0);
            check($sformatf("no_restart_busy[%0d]", inst), out_busy(inst), 1'b0);
            check($sformatf("idle_tx[%0d]", inst), out_tx(inst), 1'b1);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            check("reset_tx", tx1, 1'b1);
            check("reset_busy", busy1, 1'b0);
            check("reset_done", done1, 1'b0);
            check("reset_tx2", tx2, 1'b1);
            tick();
        end

        run_frame(0, 8'hA5, 1);
        run_frame(0, 8'hA5, 4);
        run_frame(0, 8'h07, 1);
        run_frame(1, 8'h00, 1);
        run_frame(1, 8'h5A, 2);

        // Reset during data bit 3 of 8'hFF abandons the frame silently.
        set_dv(0, 1'b1, 8'hFF);
        for (int k = 0; k <= 4 * CPB; k++) begin
            tick();
            if (k == 0) set_dv(0, 1'b0, 8'hFF);
            check("pre_reset_busy", busy1, 1'b1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_tx", tx1, 1'b1);
        check("mid_reset_busy", busy1, 1'b0);
        check("mid_reset_done", done1, 1'b0);
        for (int k = 0; k < 3 * CPB * 10; k++) begin
            tick();
            check("post_reset_done", done1, 1'b0);
            check("post_reset_tx", tx1, 1'b1);
        end
        run_frame(0, 8'hFF, 1);

        for (int r = 0; r < 12; r++) begin
            run_frame(r % 2, WIDTH'($urandom_range(0, 255)), int'($urandom_range(1, 4)));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter sitting directly downstream of the FIFO-to-UART controller in the test-counter datapath. It accepts one parallel word per `i_dv` handshake, serialises it as an asynchronous 8N1-style frame on `o_tx`, and reports activity on `o_busy`. The controller's handshake depends on the rising and falling edges of `o_busy`.

## Interface
- `WIDTH`, default 8: data bits per frame; legal range 5–9.
- `CLKS_PER_BIT`, default 434: clk cycles per bit period (50 MHz / 115200); must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits; legal values 1 or 2.
- `clk`, input, 1: clock.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_dv`, input, 1: data valid; sampled only in IDLE, may stay high for several cycles.
- `i_data`, input, WIDTH: word to send; captured in the same cycle `i_dv` is accepted.
- `o_tx`, output, 1: serial line; idles high.
- `o_busy`, output, 1: high from the cycle after acceptance until the end of the last stop bit.
- `o_done`, output, 1: one-cycle pulse marking frame completion.

## Operation
- Reset values: `o_tx`=1, `o_busy`=0, `o_done`=0; state IDLE; bit counter, baud counter and shift register all 0.
- States and transitions:
  - IDLE → START when `i_dv`=1; `i_data` is latched into the shift register.
  - START → DATA after one bit period.
  - DATA → PARITY (if compiled in) or STOP after WIDTH bit periods.
  - PARITY → STOP after one bit period.
  - STOP → IDLE after STOP_BITS bit periods.
- Line levels per state:
  - START: `o_tx`=0.
  - DATA: LSB first; the shift register shifts right once per bit period.
  - STOP: `o_tx`=1.
  - IDLE: `o_tx`=1.
- `i_dv` is ignored outside IDLE. A `i_dv` still high on the IDLE re-entry cycle starts a new frame. The controller guarantees `i_dv` is low by then.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0 to CLKS_PER_BIT−1 and produces a bit-end tick at the terminal count, then wraps to 0. It is cleared on every state entry.
- The bit counter is `$clog2(WIDTH)` bits wide. It is cleared on DATA entry and on STOP entry, and increments on each bit-end tick.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset mid-frame: on the next edge, `o_tx`=1, `o_busy`=0, state IDLE. The partial frame is abandoned and `o_done` does not pulse.

## Timing
- Cycle N: `i_dv`=1 in IDLE.
- Cycle N+1: `o_busy`=1 and `o_tx`=0. The start bit's first cycle is N+1.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- `o_busy` stays high for exactly (1+WIDTH+P+STOP_BITS)·CLKS_PER_BIT cycles, where P = 1 with parity, 0 without.
- On the cycle `o_busy` falls, `o_done`=1 for exactly one cycle and `o_tx` remains 1.
- Minimum gap between frames is 1 cycle (IDLE dwell). Back-to-back frames show `o_busy` low for ≥ 1 cycle so the controller sees the falling edge.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - The PARITY state is compiled in.
  - It transmits the even-parity bit (XOR of all WIDTH data bits) for one bit period between the last data bit and the first stop bit.
- `UART_TX_PARITY_EN` undefined:
  - There is no PARITY state and no parity logic.
  - DATA proceeds directly to STOP, giving frame length (1+WIDTH+STOP_BITS) bit periods.

## Structure
- Package `uart_pkg`:
  - `uart_tx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - Localparam `UART_DEFAULT_CLKS_PER_BIT` = 434.
  - Parity helper function.
- Sub-module `uart_baud_counter`:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, i_reset, i_clear.
  - Output o_tick, a one-cycle pulse at the terminal count.
  - Reusable by a future uart_rx.

## Test plan
- Reset then idle, CLKS_PER_BIT=4: `o_tx`=1, `o_busy`=0, `o_done`=0 held for 20 cycles with `i_dv`=0.
- Send 8'hA5 (no parity, 1 stop), CLKS_PER_BIT=4:
  - Line shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `o_busy` is high for 40 cycles.
  - `o_done` pulses on cycle 41 after `i_dv`.
- `i_dv` held high 3 cycles after acceptance, emulating the controller's lagging `i_dv`: exactly one frame is sent and no second start bit follows.
- `UART_TX_PARITY_EN`, send 8'h07, CLKS_PER_BIT=4: parity bit = 1 (three ones), followed by stop; `o_busy` is high for 44 cycles.
- STOP_BITS=2, send 8'h00: 8 data zeros, then the line is high for 8 cycles before `o_busy` falls.
- `i_reset` asserted at data bit 3 of 8'hFF: the next cycle shows `o_tx`=1 and `o_busy`=0, there is no `o_done` pulse, and a following `i_dv` sends a full clean frame.
